// File: rtl/cube_layer_scanner_pkg.sv
// Shared definitions for the cube layer scanner: default geometry and scan FSM encoding.
package cube_layer_scanner_pkg;

  localparam int unsigned CUBE_N_LAYER = 8;
  localparam int unsigned CUBE_N_LED   = 64;

  // Scan sequence per layer: LOAD -> SHIFT -> WAIT -> BLANK -> LOAD
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BLANK = 2'd3
  } scan_state_e;

endpackage

// File: rtl/sr595_shifter.sv
// Serialises one layer word into a 74HC595 chain, MSB first.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load, load_data   start a new shift with this word (1-cycle pulse)
//   ser_data, ser_clk serial data / shift clock to the chain (ser_clk idles low)
//   done_c            high in the last cycle of the shift (combinational)
module sr595_shifter #(
  parameter int unsigned N_LED   = 64,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N_LED-1:0] load_data,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             done_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = (N_LED > 1) ? $clog2(N_LED) : 1;

  logic [N_LED-1:0] sreg;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             active;
  logic             tick_c;

  // Serial data is the top bit of the shift register, so it only moves on the falling ser_clk edge.
  assign ser_data = sreg[N_LED-1];
  assign tick_c   = active && (div_cnt == CW'(CLK_DIV - 1));
  assign done_c   = tick_c && ser_clk && (bit_cnt == BW'(N_LED - 1));

  // Prescaler, half-period toggling and bit counting
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      ser_clk <= 1'b0;
    end else if (load) begin
      sreg    <= load_data;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
      ser_clk <= 1'b0;
    end else if (active) begin
      if (tick_c) begin
        div_cnt <= '0;
        if (!ser_clk) begin
          ser_clk <= 1'b1;
        end else begin
          ser_clk <= 1'b0;
          if (done_c) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            sreg    <= {sreg[N_LED-2:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cube_layer_scanner.sv
// Time-multiplexes a held 8x64 cube frame onto a 595 column chain and one-hot layer drivers.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_cube_flat   current frame; layer i at [i*N_LED +: N_LED]
//   ser_data/ser_clk  serial column data and shift clock
//   ser_latch         storage-register latch pulse
//   ser_oe_n          column output enable, active low
//   layer_sel         one-hot layer driver enable
//   scan_layer        index of the lit layer
//   frame_done        pulse when the last layer becomes lit
module cube_layer_scanner
  import cube_layer_scanner_pkg::*;
#(
  parameter int unsigned N_LAYER      = CUBE_N_LAYER,
  parameter int unsigned N_LED        = CUBE_N_LED,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DWELL_CYCLES = 20000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_LAYER*N_LED-1:0] frame_cube_flat,
  output logic                     ser_data,
  output logic                     ser_clk,
  output logic                     ser_latch,
  output logic                     ser_oe_n,
  output logic [N_LAYER-1:0]       layer_sel,
  output logic [2:0]               scan_layer,
  output logic                     frame_done
);

  localparam int unsigned LW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLANK_CYCLES);

  scan_state_e              state, next_state;
  logic [LW-1:0]            layer_idx;
  logic [DW-1:0]            dwell_cnt;
  logic [BW-1:0]            blank_cnt;
  logic                     armed;
  logic [N_LAYER*N_LED-1:0] frame_shadow;
  logic [N_LED-1:0]         layer_data_c;
  logic                     load_c;
  logic                     shift_done_c;
  logic                     blank_exit_c;
  logic                     dwell_expiring_c;

  // Counter at 1 means the lit period ends on this edge; 0 means no layer is being dwelt on.
  assign dwell_expiring_c = (dwell_cnt <= DW'(1));

  // Layer 0 comes straight from the input so the snapshot and its first layer agree.
  assign layer_data_c = (layer_idx == '0) ? frame_cube_flat[N_LED-1:0]
                                          : frame_shadow[32'(layer_idx) * N_LED +: N_LED];

  sr595_shifter #(
    .N_LED   (N_LED),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_data (layer_data_c),
    .ser_data  (ser_data),
    .ser_clk   (ser_clk),
    .done_c    (shift_done_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= next_state;
  end

  // Next-state and strobes
  always_comb begin
    next_state   = state;
    load_c       = 1'b0;
    blank_exit_c = 1'b0;
    unique case (state)
      ST_LOAD: begin
        load_c     = 1'b1;
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_done_c) next_state = dwell_expiring_c ? ST_BLANK : ST_WAIT;
      end
      ST_WAIT: begin
        if (dwell_expiring_c) next_state = ST_BLANK;
      end
      ST_BLANK: begin
        if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
          blank_exit_c = 1'b1;
          next_state   = ST_LOAD;
        end
      end
      default: next_state = ST_LOAD;
    endcase
  end

  // Frame snapshot, dwell/blank timing, layer index and registered drive outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_idx    <= '0;
      dwell_cnt    <= '0;
      blank_cnt    <= '0;
      armed        <= 1'b0;
      frame_shadow <= '0;
      ser_latch    <= 1'b0;
      ser_oe_n     <= 1'b1;
      layer_sel    <= '0;
      scan_layer   <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (load_c && (layer_idx == '0)) frame_shadow <= frame_cube_flat;
      blank_cnt  <= ((state == ST_BLANK) && !blank_exit_c) ? blank_cnt + BW'(1) : '0;
      ser_latch  <= (state == ST_BLANK) && (blank_cnt == '0);
      frame_done <= blank_exit_c && (layer_idx == LW'(N_LAYER - 1));
      if (blank_exit_c) begin
        dwell_cnt  <= DW'(DWELL_CYCLES);
        armed      <= 1'b1;
        ser_oe_n   <= 1'b0;
        layer_sel  <= N_LAYER'(1) << layer_idx;
        scan_layer <= 3'(layer_idx);
        layer_idx  <= (layer_idx == LW'(N_LAYER - 1)) ? '0 : layer_idx + LW'(1);
      end else begin
        if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - DW'(1);
        if (!armed || dwell_expiring_c) begin
          ser_oe_n  <= 1'b1;
          layer_sel <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cube_layer_scanner.sv
// Directed bench for cube_layer_scanner with CLK_DIV=1, DWELL=200, BLANK=4.
module tb_cube_layer_scanner;

  localparam int unsigned DWELL = 200;
  localparam int unsigned BLANK = 4;
  // Release to first lit: LOAD 1 + SHIFT 128 + BLANK 4
  localparam int FIRST_LIT = 133;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] frame_cube_flat = '0;
  logic         ser_data, ser_clk, ser_latch, ser_oe_n, frame_done;
  logic [7:0]   layer_sel;
  logic [2:0]   scan_layer;

  int checks = 0;
  int passed = 0;
  int mon_errs = 0;

  logic [63:0] old_l [8];
  logic [63:0] new_l [8];

  // Monitor state: words captured on ser_clk rising edges, snapshotted at each latch pulse
  logic [63:0] cap = '0;
  logic [63:0] latched = '0;
  int          cap_cnt = 0;
  int          latched_cnt = 0;
  logic        prev_clk = 1'b0;
  logic        prev_data = 1'b0;

  cube_layer_scanner #(
    .N_LAYER (8), .N_LED (64), .CLK_DIV (1),
    .DWELL_CYCLES (DWELL), .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk), .rst (rst), .frame_cube_flat (frame_cube_flat),
    .ser_data (ser_data), .ser_clk (ser_clk), .ser_latch (ser_latch),
    .ser_oe_n (ser_oe_n), .layer_sel (layer_sel), .scan_layer (scan_layer),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Invariant monitor and serial capture
  always @(negedge clk) begin
    if (!$onehot0(layer_sel)) begin
      mon_errs++;
      $display("FAIL onehot: layer_sel=%h", layer_sel);
    end
    if (ser_latch && (!ser_oe_n || layer_sel != 8'h00)) begin
      mon_errs++;
      $display("FAIL latch_blank: oe_n=%b layer_sel=%h", ser_oe_n, layer_sel);
    end
    if (!rst && prev_clk && ser_clk && (ser_data !== prev_data)) begin
      mon_errs++;
      $display("FAIL data_stable: ser_data %b -> %b while ser_clk high", prev_data, ser_data);
    end
    if (rst) begin
      cap_cnt = 0;
    end else begin
      if (!prev_clk && ser_clk) begin
        cap = {cap[62:0], ser_data};
        cap_cnt++;
      end
      if (ser_latch) begin
        latched     = cap;
        latched_cnt = cap_cnt;
        cap_cnt     = 0;
      end
    end
    prev_clk  = ser_clk;
    prev_data = ser_data;
  end

  task automatic set_frame(input bit use_new);
    for (int i = 0; i < 8; i++)
      frame_cube_flat[i*64 +: 64] = use_new ? new_l[i] : old_l[i];
  endtask

  // Advance from inside a lit period to the first cycle of the next one
  task automatic wait_lit_start(output bit ok);
    int n = 0;
    while (ser_oe_n === 1'b0 && n < 1000) begin @(negedge clk); n++; end
    while (ser_oe_n === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    ok = (ser_oe_n === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ser_oe_n !== 1'b1) $display("FAIL rst_oe_n: got %b want 1", ser_oe_n); else passed++;
    checks++; if (layer_sel !== 8'h00) $display("FAIL rst_layer_sel: got %h want 00", layer_sel); else passed++;
    checks++; if (ser_clk !== 1'b0) $display("FAIL rst_ser_clk: got %b want 0", ser_clk); else passed++;
    checks++; if (ser_latch !== 1'b0) $display("FAIL rst_latch: got %b want 0", ser_latch); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else passed++;
    checks++; if (scan_layer !== 3'd0) $display("FAIL rst_scan_layer: got %0d want 0", scan_layer); else passed++;
    checks++; if (ser_data !== 1'b0) $display("FAIL rst_ser_data: got %b want 0", ser_data); else passed++;
  endtask

  task automatic test_shift_layer0();
    logic [63:0] bits = '0;
    logic        pc = 1'b0;
    int edges = 0, edges_at_latch = -1, latch_at = -1, lit_at = -1, n = 0;
    rst = 1'b0;
    while (lit_at < 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (!pc && ser_clk) begin bits = {bits[62:0], ser_data}; edges++; end
      pc = ser_clk;
      if (ser_latch && latch_at < 0) begin latch_at = n; edges_at_latch = edges; end
      if (layer_sel != 8'h00) lit_at = n;
    end
    checks++; if (bits !== 64'h8000_0000_0000_0001) $display("FAIL l0_bits: got %h want 8000000000000001", bits); else passed++;
    checks++; if (edges_at_latch !== 64) $display("FAIL l0_edges: got %0d want 64", edges_at_latch); else passed++;
    checks++; if (latch_at !== 130) $display("FAIL l0_latch_cycle: got %0d want 130", latch_at); else passed++;
    checks++; if (lit_at !== FIRST_LIT) $display("FAIL l0_lit_cycle: got %0d want %0d", lit_at, FIRST_LIT); else passed++;
    checks++; if (layer_sel !== 8'h01) $display("FAIL l0_layer_sel: got %h want 01", layer_sel); else passed++;
    checks++; if (latched_cnt !== 64) $display("FAIL l0_latched_cnt: got %0d want 64", latched_cnt); else passed++;
  endtask

  // Entered on the first lit cycle of layer 0; walks layers 0..7 and 0 again
  task automatic test_free_run();
    logic [7:0] exp_sel = 8'h01;
    int lo, hi, fd = 0, sel_bad = 0, fd_bad = 0;
    for (int k = 0; k < 9; k++) begin
      checks++; if (latched !== old_l[k % 8]) $display("FAIL run_data[%0d]: got %h want %h", k, latched, old_l[k % 8]); else passed++;
      checks++; if (scan_layer !== 3'(k % 8)) $display("FAIL run_scan_layer[%0d]: got %0d want %0d", k, scan_layer, k % 8); else passed++;
      lo = 0;
      while (ser_oe_n === 1'b0 && lo < 1000) begin
        if (layer_sel !== exp_sel) sel_bad++;
        if (frame_done === 1'b1) begin
          fd++;
          if (exp_sel !== 8'h80 || lo != 0) fd_bad++;
        end
        lo++;
        @(negedge clk);
      end
      checks++; if (lo !== DWELL) $display("FAIL run_lit_len[%0d]: got %0d want %0d", k, lo, DWELL); else passed++;
      hi = 0;
      while (ser_oe_n === 1'b1 && hi < 1000) begin
        if (layer_sel !== 8'h00 || frame_done === 1'b1) sel_bad++;
        hi++;
        @(negedge clk);
      end
      checks++; if (hi !== BLANK) $display("FAIL run_blank_len[%0d]: got %0d want %0d", k, hi, BLANK); else passed++;
      exp_sel = {exp_sel[6:0], exp_sel[7]};
    end
    checks++; if (sel_bad !== 0) $display("FAIL run_layer_sel: %0d bad cycles, want 0", sel_bad); else passed++;
    checks++; if (fd !== 1) $display("FAIL run_frame_done_count: got %0d want 1", fd); else passed++;
    checks++; if (fd_bad !== 0) $display("FAIL run_frame_done_align: %0d misaligned, want 0", fd_bad); else passed++;
  endtask

  task automatic test_frame_change();
    bit ok = 1'b1;
    int tries = 0;
    logic [63:0] exp;
    while (layer_sel !== 8'h08 && tries < 10 && ok) begin wait_lit_start(ok); tries++; end
    checks++; if (layer_sel !== 8'h08) $display("FAIL chg_reach_l3: got %h want 08", layer_sel); else passed++;
    set_frame(1'b1);
    for (int k = 4; k < 10; k++) begin
      wait_lit_start(ok);
      exp = (k < 8) ? old_l[k % 8] : new_l[k % 8];
      checks++; if (!ok) $display("FAIL chg_timeout[%0d]: got no lit layer, want lit", k); else passed++;
      checks++; if (latched !== exp) $display("FAIL chg_data[%0d]: got %h want %h", k, latched, exp); else passed++;
      checks++; if (layer_sel !== (8'h01 << (k % 8))) $display("FAIL chg_sel[%0d]: got %h want %h", k, layer_sel, 8'h01 << (k % 8)); else passed++;
    end
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ser_oe_n !== 1'b1) $display("FAIL mid_rst_oe_n: got %b want 1", ser_oe_n); else passed++;
    checks++; if (ser_clk !== 1'b0) $display("FAIL mid_rst_ser_clk: got %b want 0", ser_clk); else passed++;
    checks++; if (layer_sel !== 8'h00) $display("FAIL mid_rst_layer_sel: got %h want 00", layer_sel); else passed++;
    @(negedge clk);
    rst = 1'b0;
    while (ser_oe_n !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    checks++; if (n !== FIRST_LIT) $display("FAIL mid_rst_lit_cycle: got %0d want %0d", n, FIRST_LIT); else passed++;
    checks++; if (layer_sel !== 8'h01) $display("FAIL mid_rst_layer_sel_after: got %h want 01", layer_sel); else passed++;
    checks++; if (scan_layer !== 3'd0) $display("FAIL mid_rst_scan_layer: got %0d want 0", scan_layer); else passed++;
    checks++; if (latched !== new_l[0]) $display("FAIL mid_rst_data: got %h want %h", latched, new_l[0]); else passed++;
    checks++; if (latched_cnt !== 64) $display("FAIL mid_rst_bits: got %0d want 64", latched_cnt); else passed++;
  endtask

  task automatic test_invariants();
    checks++; if (mon_errs !== 0) $display("FAIL invariants: got %0d violations want 0", mon_errs); else passed++;
  endtask

  initial begin
    old_l[0] = 64'h8000_0000_0000_0001;
    old_l[1] = 64'h0123_4567_89AB_CDEF;
    old_l[2] = 64'hFEDC_BA98_7654_3210;
    old_l[3] = 64'hAAAA_5555_AAAA_5555;
    old_l[4] = 64'h0F0F_F0F0_00FF_FF00;
    old_l[5] = 64'hDEAD_BEEF_CAFE_F00D;
    old_l[6] = 64'h1111_2222_4444_8888;
    old_l[7] = 64'hFFFF_0000_0000_FFFF;
    for (int i = 0; i < 8; i++) new_l[i] = ~old_l[i];
    set_frame(1'b0);
    @(negedge clk);
    test_reset();
    test_shift_layer0();
    test_free_run();
    test_frame_change();
    test_reset_mid_shift();
    test_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
